sdram_port_arbiter: RTL and testbench
=====================================

// Module: sdram_port_arbiter
// PURPOSE
//  Shares the single 16-bit SDRAM controller port (rd/wr/rdy/ack handshake) between NPORTS requesters.
//  Typical requesters are the CPU memory control block and the video scanout DMA.
//  Sequences one halfword transaction at a time and returns read data to the owning port.
//  Supports locked multi-halfword sequences (32-bit accesses, bursts) with a bounded hold time.
// PARAMETERS
//  NPORTS       2   number of requesters (2..4)
//  PRIO_PORT    1   port favoured when several ports request simultaneously
//  MAX_RUN      8   max consecutive grants to PRIO_PORT while another port waits (1..15)
//  WAIT_CYCLES  2   cycles after issue before sdram_rdy is sampled (1..3)
// PORTS
//  clk_i            in   1          clock
//  rst_i            in   1          asynchronous reset, active-high
//  req_valid_i      in   NPORTS     port p requests one halfword op; held until its done_o pulse
//  req_wr_i         in   NPORTS     1=write, 0=read
//  req_lock_i       in   NPORTS     keep grant after this op (next op of same sequence follows)
//  req_addr_i       in   NPORTS*24  halfword address, port p at [24p+:24]
//  req_wdata_i      in   NPORTS*16  write data, port p at [16p+:16]
//  done_o           out  NPORTS     1-cycle pulse: port p op complete
//  rdata_o          out  16         read data, valid in the done_o cycle (shared by all ports)
//  grant_o          out  NPORTS     one-hot current owner, 0 when idle
//  sdram_rd_o       out  1          level; held until controller drops sdram_rdy_i
//  sdram_wr_o       out  1          level; same rule
//  sdram_addr_x16_o out  24         halfword address
//  sdram_wdata_o    out  16         write data
//  sdram_rdy_i      in   1          controller idle/result ready
//  sdram_rdata_i    in   16         read data, valid while sdram_rdy_i high after a read
//  sdram_ack_o      out  1          1-cycle strobe acknowledging a completed op
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; owner none; run counter 0. Reset mid-op drops rd/wr at once; no done_o is issued.
//  FSM IDLE -> ISSUE -> WAIT -> ACK -> (IDLE | ISSUE).
//  IDLE: selects owner from req_valid_i. Winner order:
//   - PRIO_PORT if requesting and run<MAX_RUN;
//   - otherwise round-robin from the port after the last owner.
//   Latches addr/wdata/wr, sets grant_o, goes to ISSUE.
//  ISSUE: sdram_rd_o or sdram_wr_o <= 1; wait counter cleared; goes to WAIT.
//  WAIT: waits WAIT_CYCLES cycles. Afterwards, first cycle with sdram_rdy_i=1:
//   - drop rd/wr;
//   - capture sdram_rdata_i into rdata_o for reads;
//   - pulse done_o[owner] and sdram_ack_o;
//   - go to ACK.
//  ACK: one cycle. rd/wr are low.
//   - If req_lock_i[owner] was 1 at the done cycle and req_valid_i[owner]=1 now: latch the new op, go to ISSUE, same owner, no re-arbitration.
//   - Otherwise grant_o <= 0 and go to IDLE.
//   Gap between locked ops is therefore 2 cycles (ACK, ISSUE).
//  Lock with req_valid_i dropped in the ACK cycle: lock released, IDLE.
//  Run counter:
//   - increments per grant of PRIO_PORT while any other port has req_valid_i high;
//   - saturates at MAX_RUN;
//   - clears when a non-priority port is granted or no other port waits.
//   - Locked continuations do not re-arbitrate. A lock longer than MAX_RUN is honoured but counted.
//  Owner's req_valid_i dropping before done_o is a protocol violation; the arbiter completes the op and discards done_o.
//  Throughput: 1 op per (3 + WAIT_CYCLES + controller latency) cycles unlocked.
//  Simultaneous: done_o and a new request from another port in the same cycle; that request is arbitrated in IDLE after ACK.
//  sdram_addr_x16_o/sdram_wdata_o are stable from ISSUE until the end of ACK.
// STRUCTURE
//  Shared package poly94_mem_pkg:
//   - typedef arb_state_t {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_ACK};
//   - SDRAM_AW=24, SDRAM_DW=16;
//   - typedef sdram_req_t {wr, lock, addr, wdata}.
//  One sub-module: rr_pick (combinational round-robin one-hot picker, NPORTS wide, with priority override input).
//  Everything else, including the FSM, counters and latches, is inline.
// TESTING
//  Bench models the controller with rdy low for 3 cycles after rd/wr, and returns rdata = addr[15:0]^16'hA5A5.
//  1. Single read port0 addr 24'h000100 -> one rd, done_o=01, rdata_o=16'hA4A5, sdram_ack_o 1 cycle, grant_o back to 0.
//  2. Port0 write (lock=1) 24'h10 then 24'h11 -> two wr ops; port1 requesting throughout is not granted until the second done.
//  3. Ports 0,1 request continuously, MAX_RUN=8 -> port1 gets exactly 8 grants, then port0 1, repeating.
//  4. Port0 requests in the same cycle its done_o fires for port1 -> port0 issued 2 cycles after ACK; no lost or duplicated done_o.
//  5. Assert rst_i while in WAIT -> sdram_rd_o/wr_o, grant_o, done_o go 0 immediately; after release, IDLE serves a fresh request normally.
//  6. Lock=1 then req_valid dropped in the ACK cycle -> arbiter returns to IDLE; port1 is then granted.

Source files
------------

// File: rtl/poly94_mem_pkg.sv
// Shared memory-subsystem types: arbiter FSM states, SDRAM port widths and the latched request record.
package poly94_mem_pkg;

  localparam int SDRAM_AW = 24;
  localparam int SDRAM_DW = 16;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_ACK   = 2'd3
  } arb_state_t;

  typedef struct packed {
    logic                wr;
    logic                lock;
    logic [SDRAM_AW-1:0] addr;
    logic [SDRAM_DW-1:0] wdata;
  } sdram_req_t;

  // Priority-run bookkeeping: count priority grants only while someone else is being held off.
  function automatic logic [3:0] run_update(input logic [3:0] run, input logic is_prio,
                                            input logic others_wait, input logic [3:0] max_run);
    logic [3:0] res;
    if (!is_prio || !others_wait) res = 4'd0;
    else if (run >= max_run)      res = max_run;
    else                          res = run + 4'd1;
    return res;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational one-hot picker: priority port when enabled and requesting, otherwise
// round-robin starting at the port after last_i.
module rr_pick #(
  parameter int NPORTS    = 2,
  parameter int PRIO_PORT = 1,
  parameter int IW        = 1
) (
  input  logic [NPORTS-1:0] req_i,
  input  logic [IW-1:0]     last_i,
  input  logic              prio_en_i,
  output logic [NPORTS-1:0] gnt_o,
  output logic [IW-1:0]     idx_o,
  output logic              any_o
);

  always_comb begin : pick
    logic found;
    int   j;
    gnt_o = '0;
    idx_o = '0;
    any_o = |req_i;
    found = 1'b0;
    j     = 0;
    if (prio_en_i && req_i[PRIO_PORT]) begin
      idx_o = IW'(PRIO_PORT);
    end else begin
      for (int i = 1; i <= NPORTS; i++) begin
        j = int'(last_i) + i;
        if (j >= NPORTS) j = j - NPORTS;
        if (!found && req_i[j]) begin
          found = 1'b1;
          idx_o = IW'(j);
        end
      end
    end
    if (any_o) gnt_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares one halfword SDRAM controller port between NPORTS requesters, one op at a time,
// with a favoured port, a bounded favoured-port run length and locked multi-op sequences.
module sdram_port_arbiter
  import poly94_mem_pkg::*;
#(
  parameter int NPORTS      = 2,
  parameter int PRIO_PORT   = 1,
  parameter int MAX_RUN     = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NPORTS-1:0]          req_valid_i,
  input  logic [NPORTS-1:0]          req_wr_i,
  input  logic [NPORTS-1:0]          req_lock_i,
  input  logic [NPORTS*SDRAM_AW-1:0] req_addr_i,
  input  logic [NPORTS*SDRAM_DW-1:0] req_wdata_i,
  output logic [NPORTS-1:0]          done_o,
  output logic [SDRAM_DW-1:0]        rdata_o,
  output logic [NPORTS-1:0]          grant_o,
  output logic                       sdram_rd_o,
  output logic                       sdram_wr_o,
  output logic [SDRAM_AW-1:0]        sdram_addr_x16_o,
  output logic [SDRAM_DW-1:0]        sdram_wdata_o,
  input  logic                       sdram_rdy_i,
  input  logic [SDRAM_DW-1:0]        sdram_rdata_i,
  output logic                       sdram_ack_o,
  output arb_state_t                 dbg_state_o
);

  // Handshake: a port raises req_valid_i with its op fields and holds them until its
  // one-cycle done_o pulse; toward the controller rd/wr stay high until rdy is seen
  // (after WAIT_CYCLES), then sdram_ack_o strobes for one cycle.

  localparam int                IW        = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam logic [IW-1:0]     PRIO_IDX  = IW'(PRIO_PORT);
  localparam logic [NPORTS-1:0] PRIO_MASK = NPORTS'(1) << PRIO_PORT;
  localparam logic [3:0]        MAX_RUN_C = 4'(MAX_RUN);
  localparam logic [1:0]        WAIT_C    = 2'(WAIT_CYCLES);

  arb_state_t          state_q, state_d;
  logic [IW-1:0]       owner_q, owner_d;
  logic [IW-1:0]       last_q, last_d;
  logic [NPORTS-1:0]   grant_q, grant_d;
  logic [3:0]          run_q, run_d;
  logic [1:0]          wait_q, wait_d;
  sdram_req_t          req_q, req_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic [NPORTS-1:0]   done_q, done_d;
  logic                ack_q, ack_d;
  logic [SDRAM_DW-1:0] rdata_q, rdata_d;

  logic [NPORTS-1:0]   pick_gnt;
  logic [IW-1:0]       pick_idx;
  logic                pick_any;
  logic                others_wait;
  logic [IW-1:0]       load_idx;
  sdram_req_t          load_req;

  rr_pick #(
    .NPORTS   (NPORTS),
    .PRIO_PORT(PRIO_PORT),
    .IW       (IW)
  ) u_pick (
    .req_i    (req_valid_i),
    .last_i   (last_q),
    .prio_en_i(run_q < MAX_RUN_C),
    .gnt_o    (pick_gnt),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  assign others_wait = |(req_valid_i & ~PRIO_MASK);

  // The op to latch comes from the arbitration winner in IDLE, or the current owner on a locked continuation.
  always_comb begin
    load_idx       = (state_q == ARB_IDLE) ? pick_idx : owner_q;
    load_req.wr    = req_wr_i[load_idx];
    load_req.lock  = req_lock_i[load_idx];
    load_req.addr  = req_addr_i[load_idx*SDRAM_AW +: SDRAM_AW];
    load_req.wdata = req_wdata_i[load_idx*SDRAM_DW +: SDRAM_DW];
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    grant_d = grant_q;
    run_d   = run_q;
    wait_d  = wait_q;
    req_d   = req_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    rdata_d = rdata_q;
    done_d  = '0;
    ack_d   = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          owner_d = pick_idx;
          last_d  = pick_idx;
          grant_d = pick_gnt;
          req_d   = load_req;
          run_d   = run_update(run_q, pick_idx == PRIO_IDX, others_wait, MAX_RUN_C);
          state_d = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        rd_d    = ~req_q.wr;
        wr_d    = req_q.wr;
        wait_d  = 2'd0;
        state_d = ARB_WAIT;
      end
      ARB_WAIT: begin
        if (wait_q < WAIT_C) begin
          wait_d = wait_q + 2'd1;
        end else if (sdram_rdy_i) begin
          rd_d = 1'b0;
          wr_d = 1'b0;
          if (!req_q.wr) rdata_d = sdram_rdata_i;
          // An owner that abandoned its request still gets its op finished, just no done_o.
          done_d[owner_q] = req_valid_i[owner_q];
          ack_d           = 1'b1;
          req_d.lock      = req_lock_i[owner_q];
          state_d         = ARB_ACK;
        end
      end
      ARB_ACK: begin
        if (req_q.lock && req_valid_i[owner_q]) begin
          req_d   = load_req;
          run_d   = run_update(run_q, owner_q == PRIO_IDX, others_wait, MAX_RUN_C);
          state_d = ARB_ISSUE;
        end else begin
          grant_d = '0;
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ARB_IDLE;
      owner_q <= '0;
      last_q  <= IW'(NPORTS - 1);
      grant_q <= '0;
      run_q   <= '0;
      wait_q  <= '0;
      req_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      done_q  <= '0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      run_q   <= run_d;
      wait_q  <= wait_d;
      req_q   <= req_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      done_q  <= done_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
    end
  end

  assign done_o           = done_q;
  assign rdata_o          = rdata_q;
  assign grant_o          = grant_q;
  assign sdram_rd_o       = rd_q;
  assign sdram_wr_o       = wr_q;
  assign sdram_addr_x16_o = req_q.addr;
  assign sdram_wdata_o    = req_q.wdata;
  assign sdram_ack_o      = ack_q;
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: controller model with 3-cycle busy time and
// rdata = addr[15:0] ^ 16'hA5A5, checked with immediate assertions.
module tb_sdram_port_arbiter;
  import poly94_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_wr, req_lock;
  logic [47:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  done, grant;
  logic [15:0] rdata, sdram_wdata, sdram_rdata;
  logic        sdram_rd, sdram_wr, sdram_rdy, sdram_ack;
  logic [23:0] sdram_addr;
  arb_state_t  dbg_state;

  int total = 0;
  int passed = 0;
  int done_cnt0 = 0;
  int done_cnt1 = 0;
  int rd_ops = 0;
  int wr_ops = 0;
  int busy = 0;
  logic prev_cmd = 1'b0;
  logic ok;
  int base0, base1;

  sdram_port_arbiter #(.NPORTS(2), .PRIO_PORT(1), .MAX_RUN(8), .WAIT_CYCLES(2)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .req_valid_i     (req_valid),
    .req_wr_i        (req_wr),
    .req_lock_i      (req_lock),
    .req_addr_i      (req_addr),
    .req_wdata_i     (req_wdata),
    .done_o          (done),
    .rdata_o         (rdata),
    .grant_o         (grant),
    .sdram_rd_o      (sdram_rd),
    .sdram_wr_o      (sdram_wr),
    .sdram_addr_x16_o(sdram_addr),
    .sdram_wdata_o   (sdram_wdata),
    .sdram_rdy_i     (sdram_rdy),
    .sdram_rdata_i   (sdram_rdata),
    .sdram_ack_o     (sdram_ack),
    .dbg_state_o     (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // controller model: rdy drops for 3 cycles after each new rd/wr
  assign sdram_rdata = sdram_addr[15:0] ^ 16'hA5A5;
  always @(posedge clk) begin
    if (rst) begin
      sdram_rdy <= 1'b1;
      busy      <= 0;
      prev_cmd  <= 1'b0;
    end else begin
      prev_cmd <= sdram_rd | sdram_wr;
      if ((sdram_rd | sdram_wr) && !prev_cmd) begin
        busy      <= 3;
        sdram_rdy <= 1'b0;
        if (sdram_rd) rd_ops <= rd_ops + 1;
        if (sdram_wr) wr_ops <= wr_ops + 1;
      end else if (busy > 1) begin
        busy <= busy - 1;
      end else if (busy == 1) begin
        busy      <= 0;
        sdram_rdy <= 1'b1;
      end
    end
    if (done[0]) done_cnt0 <= done_cnt0 + 1;
    if (done[1]) done_cnt1 <= done_cnt1 + 1;
  end

  // scoreboard check
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // driver tasks
  task automatic set_port(input int p, input logic v, input logic wr, input logic lk,
                          input logic [23:0] a, input logic [15:0] wd);
    req_valid[p]           = v;
    req_wr[p]              = wr;
    req_lock[p]            = lk;
    req_addr[p*24 +: 24]   = a;
    req_wdata[p*16 +: 16]  = wd;
  endtask

  task automatic wait_done(input logic [1:0] m, output logic found);
    found = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (|(done & m)) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_state(input arb_state_t s, output logic found);
    found = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (dbg_state == s) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0; req_wr = '0; req_lock = '0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_rdwr", {30'd0, sdram_rd, sdram_wr}, 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_ack", 32'(sdram_ack), 32'h0);
    chk("rst_rdata", 32'(rdata), 32'h0);
    chk("rst_state", 32'(dbg_state), 32'(ARB_IDLE));

    // 1: single read on port 0
    set_port(0, 1'b1, 1'b0, 1'b0, 24'h000100, 16'h0);
    repeat (2) @(negedge clk);
    chk("t1_grant", 32'(grant), 32'h1);
    chk("t1_rd", 32'(sdram_rd), 32'h1);
    chk("t1_addr", 32'(sdram_addr), 32'h100);
    wait_done(2'b01, ok);
    chk("t1_done_seen", 32'(ok), 32'h1);
    chk("t1_done", 32'(done), 32'h1);
    chk("t1_rdata", 32'(rdata), 32'hA4A5);
    chk("t1_ack", 32'(sdram_ack), 32'h1);
    chk("t1_rd_low", 32'(sdram_rd), 32'h0);
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("t1_ack_1cyc", 32'(sdram_ack), 32'h0);
    chk("t1_grant_idle", 32'(grant), 32'h0);
    chk("t1_rd_ops", 32'(rd_ops), 32'h1);

    // 2: locked two-write sequence on port 0 while port 1 waits
    set_port(0, 1'b1, 1'b1, 1'b1, 24'h000010, 16'h1234);
    @(negedge clk);
    set_port(1, 1'b1, 1'b0, 1'b0, 24'h000200, 16'h0);
    wait_done(2'b11, ok);
    chk("t2_done1", 32'(done), 32'h1);
    set_port(0, 1'b1, 1'b1, 1'b0, 24'h000011, 16'h5678);
    @(negedge clk);
    chk("t2_cont_state", 32'(dbg_state), 32'(ARB_ISSUE));
    chk("t2_cont_grant", 32'(grant), 32'h1);
    chk("t2_cont_addr", 32'(sdram_addr), 32'h11);
    chk("t2_cont_wdata", 32'(sdram_wdata), 32'h5678);
    wait_done(2'b11, ok);
    chk("t2_done2", 32'(done), 32'h1);
    chk("t2_wr_ops", 32'(wr_ops), 32'h2);
    chk("t2_p1_waiting", 32'(done_cnt1), 32'h0);
    req_valid[0] = 1'b0;
    repeat (2) @(negedge clk);
    chk("t2_p1_grant", 32'(grant), 32'h2);
    wait_done(2'b10, ok);
    chk("t2_p1_rdata", 32'(rdata), 32'hA7A5);
    req_valid[1] = 1'b0;
    @(negedge clk);

    // 3: both ports continuously requesting -> 8 grants to port 1, then 1 to port 0
    set_port(0, 1'b1, 1'b0, 1'b0, 24'h000020, 16'h0);
    set_port(1, 1'b1, 1'b0, 1'b0, 24'h000030, 16'h0);
    for (int k = 0; k < 18; k++) begin
      wait_done(2'b11, ok);
      chk($sformatf("t3_seq%0d", k), 32'(done), (k == 8 || k == 17) ? 32'h1 : 32'h2);
    end
    req_valid = 2'b00;
    @(negedge clk);

    // 4: port 0 requests in the cycle port 1's done fires
    base0 = done_cnt0;
    base1 = done_cnt1;
    set_port(1, 1'b1, 1'b0, 1'b0, 24'h000200, 16'h0);
    wait_done(2'b10, ok);
    chk("t4_p1_done", 32'(done), 32'h2);
    req_valid[1] = 1'b0;
    set_port(0, 1'b1, 1'b0, 1'b0, 24'h000050, 16'h0);
    @(negedge clk);
    chk("t4_idle", 32'(dbg_state), 32'(ARB_IDLE));
    @(negedge clk);
    chk("t4_issue", 32'(dbg_state), 32'(ARB_ISSUE));
    chk("t4_grant", 32'(grant), 32'h1);
    @(negedge clk);
    chk("t4_rd", 32'(sdram_rd), 32'h1);
    wait_done(2'b01, ok);
    chk("t4_p0_rdata", 32'(rdata), 32'hA5F5);
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("t4_cnt0", 32'(done_cnt0 - base0), 32'h1);
    chk("t4_cnt1", 32'(done_cnt1 - base1), 32'h1);

    // 5: reset while in WAIT
    base0 = done_cnt0;
    set_port(0, 1'b1, 1'b0, 1'b0, 24'h000300, 16'h0);
    wait_state(ARB_WAIT, ok);
    chk("t5_reach_wait", 32'(ok), 32'h1);
    @(negedge clk);
    chk("t5_rd_before", 32'(sdram_rd), 32'h1);
    rst = 1'b1;
    #1;
    chk("t5_rdwr", {30'd0, sdram_rd, sdram_wr}, 32'h0);
    chk("t5_grant", 32'(grant), 32'h0);
    chk("t5_done", 32'(done), 32'h0);
    chk("t5_state", 32'(dbg_state), 32'(ARB_IDLE));
    req_valid = 2'b00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    set_port(0, 1'b1, 1'b0, 1'b0, 24'h000301, 16'h0);
    wait_done(2'b01, ok);
    chk("t5_after_rdata", 32'(rdata), 32'hA6A4);
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("t5_cnt0", 32'(done_cnt0 - base0), 32'h1);

    // 6: lock held, then req_valid dropped in the ACK cycle
    set_port(0, 1'b1, 1'b0, 1'b1, 24'h000040, 16'h0);
    @(negedge clk);
    set_port(1, 1'b1, 1'b0, 1'b0, 24'h000240, 16'h0);
    wait_done(2'b11, ok);
    chk("t6_p0_done", 32'(done), 32'h1);
    chk("t6_p0_rdata", 32'(rdata), 32'hA5E5);
    set_port(0, 1'b0, 1'b0, 1'b0, 24'h0, 16'h0);
    @(negedge clk);
    chk("t6_idle", 32'(dbg_state), 32'(ARB_IDLE));
    chk("t6_grant0", 32'(grant), 32'h0);
    @(negedge clk);
    chk("t6_p1_grant", 32'(grant), 32'h2);
    wait_done(2'b11, ok);
    chk("t6_p1_done", 32'(done), 32'h2);
    chk("t6_p1_rdata", 32'(rdata), 32'hA7E5);
    req_valid[1] = 1'b0;
    repeat (2) @(negedge clk);

    // final report
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
